// File: rtl/execute_stage_pkg.sv
// Shared definitions for the EX stage: ALU operation encodings, operand
// select constants and the multiplier FSM state encoding.
package execute_stage_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_NOR    = 5'd5,
    ALU_SLT    = 5'd6,
    ALU_SLTU   = 5'd7,
    ALU_SLL    = 5'd8,
    ALU_SRL    = 5'd9,
    ALU_SRA    = 5'd10,
    ALU_LUI    = 5'd11,
    ALU_MFHI   = 5'd12,
    ALU_MFLO   = 5'd13,
    ALU_MULT   = 5'd14,
    ALU_MULTU  = 5'd15,
    ALU_PASS_A = 5'd16
  } alu_op_t;

  // Operand A select
  localparam logic SRC_A_REG   = 1'b0;
  localparam logic SRC_A_SHAMT = 1'b1;

  // Operand B select
  typedef enum logic [1:0] {
    SRC_B_REG    = 2'd0,
    SRC_B_IMM    = 2'd1,
    SRC_B_IMM_ZX = 2'd2,
    SRC_B_ZERO   = 2'd3
  } src_b_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX-side bundle of the execute stage.
// master: ID/EX register side (drives instruction fields, sees results)
// slave : execute_stage
interface execute_stage_if;
  import execute_stage_pkg::*;

  logic        Valid_EX;
  logic        Flush_EX;
  alu_op_t     ALUControl_EX;
  logic        ALUSrc0_EX;
  src_b_t      ALUSrc1_EX;
  logic [31:0] Reg_Data1_EX;
  logic [31:0] Reg_Data2_EX;
  logic [31:0] Imm32b_EX;
  logic        RegDst_EX;
  logic [4:0]  Rt_EX;
  logic [4:0]  Rd_EX;
  logic [31:0] ALUResult_EX;
  logic        Zero_EX;
  logic [4:0]  RegDestSelected_EX;
  logic        Stall_EX;

  modport master (
    output Valid_EX, Flush_EX, ALUControl_EX, ALUSrc0_EX, ALUSrc1_EX,
           Reg_Data1_EX, Reg_Data2_EX, Imm32b_EX, RegDst_EX, Rt_EX, Rd_EX,
    input  ALUResult_EX, Zero_EX, RegDestSelected_EX, Stall_EX
  );

  modport slave (
    input  Valid_EX, Flush_EX, ALUControl_EX, ALUSrc0_EX, ALUSrc1_EX,
           Reg_Data1_EX, Reg_Data2_EX, Imm32b_EX, RegDst_EX, Rt_EX, Rd_EX,
    output ALUResult_EX, Zero_EX, RegDestSelected_EX, Stall_EX
  );
endinterface

// File: rtl/execute_stage_mult_unit.sv
// Iterative 32-cycle shift-add multiplier owning the HI/LO registers.
// Ports: clk/rst, start (launch from IDLE), flush (abort), a/b operands,
// is_signed (MULT vs MULTU); busy/done state flags, hi/lo results.
module mult_unit
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mul_state_t  state;
  logic [63:0] mcand;
  logic [63:0] acc;
  logic [31:0] mplier;
  logic [4:0]  count;
  logic        neg;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] acc_next;
  logic [63:0] product;

  // Signed multiply runs on magnitudes; the sign is reapplied at the end.
  always_comb begin
    mag_a    = (is_signed && a[31]) ? (~a + 32'd1) : a;
    mag_b    = (is_signed && b[31]) ? (~b + 32'd1) : b;
    acc_next = acc + (mplier[0] ? mcand : '0);
    product  = neg ? (~acc_next + 64'd1) : acc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MUL_IDLE;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start && !flush) begin
            mcand  <= {32'd0, mag_a};
            mplier <= mag_b;
            neg    <= is_signed & (a[31] ^ b[31]);
            acc    <= '0;
            count  <= '0;
            state  <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (flush) begin
            state <= MUL_IDLE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
            if (count == 5'd31) begin
              {hi, lo} <= product;
              state    <= MUL_DONE;
            end
          end
        end
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

  assign busy = (state == MUL_BUSY);
  assign done = (state == MUL_DONE);

endmodule

// File: rtl/execute_stage.sv
// EX stage of the five-stage MIPS pipeline: operand muxes, single-cycle
// ALU with zero flag, destination register mux and the HI/LO multiplier.
// Ports: Clock, Reset (async, active-high), ex (slave side of
// execute_stage_if carrying ID/EX fields in and ALU result/zero/dest/stall out).
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic          Clock,
  input  logic          Reset,
  execute_stage_if.slave ex
);

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result;
  logic        mul_op;
  logic        mul_signed;
  logic        mul_busy;
  logic        mul_done;
  logic        mul_start;
  logic [31:0] hi;
  logic [31:0] lo;

  always_comb begin
    op_a = (ex.ALUSrc0_EX == SRC_A_SHAMT) ? {27'd0, ex.Imm32b_EX[10:6]}
                                          : ex.Reg_Data1_EX;
    case (ex.ALUSrc1_EX)
      SRC_B_REG:    op_b = ex.Reg_Data2_EX;
      SRC_B_IMM:    op_b = ex.Imm32b_EX;
      SRC_B_IMM_ZX: op_b = {16'd0, ex.Imm32b_EX[15:0]};
      SRC_B_ZERO:   op_b = '0;
      default:      op_b = '0;
    endcase
  end

  always_comb begin
    result = '0;
    case (ex.ALUControl_EX)
      ALU_ADD:    result = op_a + op_b;
      ALU_SUB:    result = op_a - op_b;
      ALU_AND:    result = op_a & op_b;
      ALU_OR:     result = op_a | op_b;
      ALU_XOR:    result = op_a ^ op_b;
      ALU_NOR:    result = ~(op_a | op_b);
      ALU_SLT:    result = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   result = {31'd0, op_a < op_b};
      ALU_SLL:    result = op_b << op_a[4:0];
      ALU_SRL:    result = op_b >> op_a[4:0];
      ALU_SRA:    result = $unsigned($signed(op_b) >>> op_a[4:0]);
      ALU_LUI:    result = {op_b[15:0], 16'd0};
      ALU_MFHI:   result = hi;
      ALU_MFLO:   result = lo;
      ALU_MULT,
      ALU_MULTU:  result = '0;
      ALU_PASS_A: result = op_a;
      default:    result = '0;
    endcase
  end

  assign mul_op     = (ex.ALUControl_EX == ALU_MULT) || (ex.ALUControl_EX == ALU_MULTU);
  assign mul_signed = (ex.ALUControl_EX == ALU_MULT);
  // Launch only from idle; the instruction stays in ID/EX while stalled.
  assign mul_start  = ex.Valid_EX & mul_op & ~mul_busy & ~mul_done;

  mult_unit u_mult (
    .clk       (Clock),
    .rst       (Reset),
    .start     (mul_start),
    .flush     (ex.Flush_EX),
    .is_signed (mul_signed),
    .a         (op_a),
    .b         (op_b),
    .busy      (mul_busy),
    .done      (mul_done),
    .hi        (hi),
    .lo        (lo)
  );

  assign ex.ALUResult_EX       = result;
  assign ex.Zero_EX            = (result == '0);
  assign ex.RegDestSelected_EX = ex.RegDst_EX ? ex.Rd_EX : ex.Rt_EX;
  // Flush and reset release the stall combinationally in the same cycle.
  assign ex.Stall_EX = ex.Valid_EX & mul_op & ~mul_done & ~ex.Flush_EX & ~Reset;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  execute_stage_if ex ();

  execute_stage dut (
    .Clock (Clock),
    .Reset (Reset),
    .ex    (ex)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    alu_op_t     op;
    logic        src0;
    src_b_t      src1;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic        regdst;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        zero;
    logic [4:0]  dest;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input alu_op_t op, input logic src0, input src_b_t src1,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                       input logic regdst, input logic [4:0] rt, input logic [4:0] rd,
                       input logic valid);
    ex.Valid_EX      = valid;
    ex.ALUControl_EX = op;
    ex.ALUSrc0_EX    = src0;
    ex.ALUSrc1_EX    = src1;
    ex.Reg_Data1_EX  = r1;
    ex.Reg_Data2_EX  = r2;
    ex.Imm32b_EX     = imm;
    ex.RegDst_EX     = regdst;
    ex.Rt_EX         = rt;
    ex.Rd_EX         = rd;
  endtask

  // Called at a falling edge; returns one #1 into the DONE cycle (cycle 33).
  task automatic mul_run(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    drive(op, SRC_A_REG, SRC_B_REG, a, b, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    #1;
    for (int c = 0; c <= 32; c++) begin
      check($sformatf("mul_stall_c%0d", c), {31'd0, ex.Stall_EX}, 32'd1);
      check("mul_result_zero", ex.ALUResult_EX, 32'd0);
      @(negedge Clock); #1;
    end
    check("mul_stall_done", {31'd0, ex.Stall_EX}, 32'd0);
  endtask

  task automatic read_hilo(input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge Clock);
    drive(ALU_MFHI, SRC_A_REG, SRC_B_REG, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    #1;
    check("mfhi", ex.ALUResult_EX, exp_hi);
    check("mfhi_stall", {31'd0, ex.Stall_EX}, 32'd0);
    drive(ALU_MFLO, SRC_A_REG, SRC_B_REG, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    #1;
    check("mflo", ex.ALUResult_EX, exp_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"add_ovf",  ALU_ADD,    SRC_A_REG,   SRC_B_REG,    32'h7FFFFFFF, 32'h1,        32'h0,        1'b0, 5'd3, 5'd0, 32'h80000000, 1'b0, 5'd3};
    vecs[1]  = '{"sub_zero", ALU_SUB,    SRC_A_REG,   SRC_B_REG,    32'd5,        32'd5,        32'h0,        1'b0, 5'd4, 5'd0, 32'h0,        1'b1, 5'd4};
    vecs[2]  = '{"slt",      ALU_SLT,    SRC_A_REG,   SRC_B_REG,    32'hFFFFFFFF, 32'd1,        32'h0,        1'b0, 5'd1, 5'd0, 32'd1,        1'b0, 5'd1};
    vecs[3]  = '{"sltu",     ALU_SLTU,   SRC_A_REG,   SRC_B_REG,    32'hFFFFFFFF, 32'd1,        32'h0,        1'b0, 5'd2, 5'd0, 32'd0,        1'b1, 5'd2};
    vecs[4]  = '{"sra",      ALU_SRA,    SRC_A_SHAMT, SRC_B_REG,    32'hFFFFFFFF, 32'h80000000, 32'h100,      1'b0, 5'd5, 5'd0, 32'hF8000000, 1'b0, 5'd5};
    vecs[5]  = '{"lui",      ALU_LUI,    SRC_A_REG,   SRC_B_IMM_ZX, 32'h0,        32'h0,        32'h1234,     1'b0, 5'd6, 5'd0, 32'h12340000, 1'b0, 5'd6};
    vecs[6]  = '{"and_rd",   ALU_AND,    SRC_A_REG,   SRC_B_REG,    32'h0000F0F0, 32'h0000FF00, 32'h0,        1'b1, 5'd3, 5'd7, 32'h0000F000, 1'b0, 5'd7};
    vecs[7]  = '{"or_zero",  ALU_OR,     SRC_A_REG,   SRC_B_ZERO,   32'h55,       32'hFFFF,     32'h0,        1'b0, 5'd3, 5'd9, 32'h55,       1'b0, 5'd3};
    vecs[8]  = '{"xor",      ALU_XOR,    SRC_A_REG,   SRC_B_REG,    32'hA5A5A5A5, 32'hFFFFFFFF, 32'h0,        1'b0, 5'd8, 5'd0, 32'h5A5A5A5A, 1'b0, 5'd8};
    vecs[9]  = '{"nor",      ALU_NOR,    SRC_A_REG,   SRC_B_REG,    32'h0,        32'h0,        32'h0,        1'b1, 5'd0, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd31};
    vecs[10] = '{"sll31",    ALU_SLL,    SRC_A_SHAMT, SRC_B_REG,    32'h0,        32'd3,        32'h7C0,      1'b0, 5'd10, 5'd0, 32'h80000000, 1'b0, 5'd10};
    vecs[11] = '{"srl",      ALU_SRL,    SRC_A_SHAMT, SRC_B_REG,    32'h0,        32'h80000000, 32'h100,      1'b0, 5'd11, 5'd0, 32'h08000000, 1'b0, 5'd11};
    vecs[12] = '{"pass_a",   ALU_PASS_A, SRC_A_REG,   SRC_B_REG,    32'hDEADBEEF, 32'h1,        32'h0,        1'b0, 5'd12, 5'd0, 32'hDEADBEEF, 1'b0, 5'd12};
    vecs[13] = '{"add_wrap", ALU_ADD,    SRC_A_REG,   SRC_B_REG,    32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 5'd13, 5'd0, 32'h0,        1'b1, 5'd13};
    vecs[14] = '{"add_imm",  ALU_ADD,    SRC_A_REG,   SRC_B_IMM,    32'd5,        32'h0,        32'hFFFFFFFE, 1'b0, 5'd14, 5'd0, 32'd3,        1'b0, 5'd14};

    ex.Flush_EX = 1'b0;
    drive(ALU_MULT, SRC_A_REG, SRC_B_REG, 32'd3, 32'd4, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    #1;
    check("reset_stall", {31'd0, ex.Stall_EX}, 32'd0);
    check("reset_state", 32'(dut.u_mult.state), 32'(MUL_IDLE));
    @(negedge Clock);
    drive(ALU_MFHI, SRC_A_REG, SRC_B_REG, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    #1;
    check("reset_hi", ex.ALUResult_EX, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge Clock);
      drive(vecs[i].op, vecs[i].src0, vecs[i].src1, vecs[i].r1, vecs[i].r2, vecs[i].imm,
            vecs[i].regdst, vecs[i].rt, vecs[i].rd, 1'b1);
      #1;
      check({vecs[i].name, "_res"},   ex.ALUResult_EX, vecs[i].res);
      check({vecs[i].name, "_zero"},  {31'd0, ex.Zero_EX}, {31'd0, vecs[i].zero});
      check({vecs[i].name, "_dest"},  {27'd0, ex.RegDestSelected_EX}, {27'd0, vecs[i].dest});
      check({vecs[i].name, "_stall"}, {31'd0, ex.Stall_EX}, 32'd0);
    end

    // Invalid MULT must not stall or start
    @(negedge Clock);
    drive(ALU_MULT, SRC_A_REG, SRC_B_REG, 32'd3, 32'd4, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    #1;
    check("invalid_mult_stall", {31'd0, ex.Stall_EX}, 32'd0);
    @(negedge Clock); #1;
    check("invalid_mult_state", 32'(dut.u_mult.state), 32'(MUL_IDLE));

    // Signed MULT -3 x 7
    @(negedge Clock);
    mul_run(ALU_MULT, 32'hFFFFFFFD, 32'd7);
    read_hilo(32'hFFFFFFFF, 32'hFFFFFFEB);

    // MULTU max x max
    @(negedge Clock);
    mul_run(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    read_hilo(32'hFFFFFFFE, 32'h00000001);

    // Back-to-back MULTU
    @(negedge Clock);
    mul_run(ALU_MULTU, 32'd7, 32'd9);
    @(negedge Clock);
    mul_run(ALU_MULTU, 32'd2, 32'd3);
    read_hilo(32'd0, 32'd6);

    // Flush at BUSY cycle 15, then a new MULT the following cycle
    @(negedge Clock);
    drive(ALU_MULT, SRC_A_REG, SRC_B_REG, 32'h100, 32'h100, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    repeat (15) @(negedge Clock);
    ex.Flush_EX = 1'b1;
    #1;
    check("flush_stall", {31'd0, ex.Stall_EX}, 32'd0);
    @(negedge Clock);
    ex.Flush_EX = 1'b0;
    check("flush_state", 32'(dut.u_mult.state), 32'(MUL_IDLE));
    check("flush_hi", dut.u_mult.hi, 32'd0);
    check("flush_lo", dut.u_mult.lo, 32'd6);
    mul_run(ALU_MULT, 32'h100, 32'hFFFFFFFE);
    read_hilo(32'hFFFFFFFF, 32'hFFFFFE00);

    // Reset at cycle 10 of a MULT
    @(negedge Clock);
    drive(ALU_MULT, SRC_A_REG, SRC_B_REG, 32'd5, 32'd5, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    repeat (10) @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("rst_mid_stall", {31'd0, ex.Stall_EX}, 32'd0);
    check("rst_mid_state", 32'(dut.u_mult.state), 32'(MUL_IDLE));
    ex.ALUControl_EX = ALU_MFHI;
    #1;
    check("rst_mid_hi", ex.ALUResult_EX, 32'd0);
    ex.ALUControl_EX = ALU_MFLO;
    #1;
    check("rst_mid_lo", ex.ALUResult_EX, 32'd0);
    ex.ALUControl_EX = ALU_MULT;
    for (int c = 0; c < 2; c++) begin
      @(negedge Clock); #1;
      check("rst_hold_stall", {31'd0, ex.Stall_EX}, 32'd0);
    end
    ex.Valid_EX = 1'b0;
    Reset = 1'b0;
    @(negedge Clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (EX) stage of the five-stage MIPS pipeline, sitting between the ID/EX pipeline register and the EX/MEM register. It selects ALU operands, computes single-cycle ALU results and the zero flag, and resolves the write-back destination register. It also contains an iterative 32-cycle multiplier that writes HI/LO and stalls the front of the pipeline while busy.

## Interface
- No parameters; data width fixed at 32.
- Clock  in  1  pipeline clock, rising edge
- Reset  in  1  asynchronous, active-high
- Valid_EX  in  1  ID/EX register holds a live instruction
- Flush_EX  in  1  squash the current EX instruction, synchronous
- ALUControl_EX  in  5  operation code; encodings are in the shared package
- ALUSrc0_EX  in  1  operand A select: 0 = Reg_Data1, 1 = zero-extended Imm32b[10:6] (shamt)
- ALUSrc1_EX  in  2  operand B select: 0 = Reg_Data2, 1 = Imm32b, 2 = {16'b0, Imm32b[15:0]}, 3 = 32'd0
- Reg_Data1_EX, Reg_Data2_EX, Imm32b_EX  in  32 each  operands from ID
- RegDst_EX  in  1  0 = Rt, 1 = Rd
- Rt_EX, Rd_EX  in  5 each  register specifiers
- ALUResult_EX  out  32  ALU result or HI/LO read
- Zero_EX  out  1  ALUResult_EX == 0
- RegDestSelected_EX  out  5  chosen destination register
- Stall_EX  out  1  hold PC, IF/ID and ID/EX; insert a bubble into EX/MEM

## Operation
- Supported ops: ADD, SUB, AND, OR, XOR, NOR, SLT (signed), SLTU, SLL, SRL, SRA, LUI, MFHI, MFLO, MULT, MULTU, PASS_A.
- All arithmetic wraps modulo 2^32. No overflow trap.
- Shifts use operand A[4:0] as the shift amount and operand B as the data.
- LUI result = {B[15:0], 16'b0}.
- ALU ops, MFHI and MFLO are combinational.
- ALUResult_EX for MULT/MULTU is 0.
- When Valid_EX = 0, outputs still compute, but Stall_EX = 0 and the multiplier does not start.
- Multiplier FSM states: IDLE, BUSY, DONE.
  - IDLE: on Valid and MULT/MULTU and not Flush:
    - latch |A| and |B| (raw values for MULTU);
    - latch the result sign (A[31]^B[31] for MULT);
    - clear the 64-bit accumulator and the 5-bit counter;
    - go to BUSY.
  - BUSY: each cycle, add the shifted multiplicand if the current multiplier bit is 1, then shift. The counter increments and wraps from 31 to 0. At counter 31, write {HI,LO} (negated if the sign flag is set) and go to DONE.
  - DONE: unconditionally return to IDLE next cycle.
- Stall_EX = Valid and mul op and state != DONE. The instruction retires in the DONE cycle.
- Flush_EX in BUSY or DONE returns the FSM to IDLE. HI/LO are not written, and Stall_EX drops in the same cycle (combinational on Flush).
- MFHI/MFLO following a MULT read the updated HI/LO, because the MULT stall guarantees completion first.
- HI/LO change only on multiply completion or reset.

## Timing
- Reset: state IDLE, HI = LO = 0, counter 0, Stall_EX = 0. The remaining outputs are combinational functions of the inputs.
- Reset asserted mid-multiply aborts it immediately. HI/LO go to 0.
- MULT latency: present in cycle 0 (IDLE, stall), BUSY cycles 1–32 (stall), HI/LO updated at the edge ending cycle 32, DONE cycle 33 (Stall_EX = 0).
- A MULT occupies EX for 34 cycles.
- A MULT immediately following a MULT starts from IDLE in the cycle after DONE.
- ALU result latency is zero cycles. It is captured by the EX/MEM register on the next edge.

## Structure
- Shared package: ALUControl encodings, ALUSrc0/ALUSrc1 select constants, FSM state encoding.
- One sub-module, mult_unit. It owns the FSM, counter, accumulator, and the HI/LO registers. Its ports are start/flush/operands/signed in, and busy/done/HI/LO out.
- The operand muxes, ALU and destination mux are in execute_stage.

## Test plan
- Reset mid-BUSY: assert Reset at cycle 10 of a MULT → state IDLE, HI = LO = 0, Stall_EX = 0 while Reset is held.
- ADD 0x7FFFFFFF + 1, then SUB 5 - 5 → 0x80000000 with Zero 0, then 0 with Zero 1. SLT -1,1 → 1; SLTU -1,1 → 0.
- SRA of 0x80000000 by shamt 4 (ALUSrc0 = 1) → 0xF8000000. LUI with imm 0x1234 → 0x12340000. RegDst = 1 with Rd = 7 → RegDestSelected_EX = 7.
- MULT -3 × 7 → Stall_EX high for cycles 0–32 and low at 33; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. MFHI then MFLO return those values.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. A back-to-back MULTU 2 × 3 gives LO = 6 after a further 34 cycles.
- Flush_EX at BUSY cycle 15 → Stall_EX drops the same cycle and HI/LO keep their prior values. A new MULT issued in the following cycle completes normally.
